// File: rtl/lane_vrf_write_arbiter_pkg.sv
// rtl/lane_vrf_write_arbiter_pkg.sv - shared types and widths for the lane VRF write arbiter
package lane_vrf_write_arbiter_pkg;

    localparam int DATA_WIDTH   = 32;
    localparam int MASK_WIDTH   = DATA_WIDTH / 8;
    localparam int OFFSET_WIDTH = 9;
    localparam int VD_WIDTH     = 5;
    localparam int INST_SLOTS   = 8;
    localparam int IDX_WIDTH    = $clog2(INST_SLOTS);

    typedef struct packed {
        logic [VD_WIDTH-1:0]     vd;
        logic [OFFSET_WIDTH-1:0] offset;
        logic [MASK_WIDTH-1:0]   mask;
        logic [DATA_WIDTH-1:0]   data;
        logic                    last;
        logic [IDX_WIDTH-1:0]    instructionIndex;
    } vrf_write_req_t;

endpackage

// File: rtl/lane_write_fifo.sv
// rtl/lane_write_fifo.sv - registered FIFO, ready = ~full, no flow-through
module lane_write_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  T     in_tdata,
    input  logic in_tvalid,
    output logic in_tready,
    output T     out_tdata,
    output logic out_tvalid,
    input  logic out_tready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push, pop;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A pop in the same cycle never opens a slot for that cycle's push.
    assign in_tready  = (count_q != CNT_W'(DEPTH));
    assign out_tvalid = (count_q != '0);
    assign out_tdata  = mem_q[rd_ptr_q];
    assign push       = in_tvalid & in_tready;
    assign pop        = out_tvalid & out_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_tdata;
                wr_ptr_q        <= inc_ptr(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= inc_ptr(rd_ptr_q);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/lane_vrf_write_arbiter.sv
// rtl/lane_vrf_write_arbiter.sv - round-robin merge of stage3/LSU VRF writes with in-flight tracking
module lane_vrf_write_arbiter
    import lane_vrf_write_arbiter_pkg::*;
#(
    parameter int OUT_DEPTH = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    stageWrite_valid,
    output logic                    stageWrite_ready,
    input  logic [VD_WIDTH-1:0]     stageWrite_bits_vd,
    input  logic [OFFSET_WIDTH-1:0] stageWrite_bits_offset,
    input  logic [MASK_WIDTH-1:0]   stageWrite_bits_mask,
    input  logic [DATA_WIDTH-1:0]   stageWrite_bits_data,
    input  logic                    stageWrite_bits_last,
    input  logic [IDX_WIDTH-1:0]    stageWrite_bits_instructionIndex,
    input  logic                    lsuWrite_valid,
    output logic                    lsuWrite_ready,
    input  logic [VD_WIDTH-1:0]     lsuWrite_bits_vd,
    input  logic [OFFSET_WIDTH-1:0] lsuWrite_bits_offset,
    input  logic [MASK_WIDTH-1:0]   lsuWrite_bits_mask,
    input  logic [DATA_WIDTH-1:0]   lsuWrite_bits_data,
    input  logic                    lsuWrite_bits_last,
    input  logic [IDX_WIDTH-1:0]    lsuWrite_bits_instructionIndex,
    output logic                    vrfWrite_valid,
    input  logic                    vrfWrite_ready,
    output logic [VD_WIDTH-1:0]     vrfWrite_bits_vd,
    output logic [OFFSET_WIDTH-1:0] vrfWrite_bits_offset,
    output logic [MASK_WIDTH-1:0]   vrfWrite_bits_mask,
    output logic [DATA_WIDTH-1:0]   vrfWrite_bits_data,
    output logic                    vrfWrite_bits_last,
    output logic [IDX_WIDTH-1:0]    vrfWrite_bits_instructionIndex,
    output logic [INST_SLOTS-1:0]   instructionWriting,
    output logic [INST_SLOTS-1:0]   writeLastReport
);

    localparam int CNT_W = $clog2(OUT_DEPTH + 1);

    vrf_write_req_t        stage_req, lsu_req, win_req, head_req;
    logic                  prefer_lsu_q;
    logic                  grant_stage, grant_lsu, fifo_ready;
    logic                  stage_acc, lsu_acc, enq, pop;
    logic [CNT_W-1:0]      count_q [INST_SLOTS];
    logic [CNT_W-1:0]      count_d [INST_SLOTS];
    logic [INST_SLOTS-1:0] report_q, report_d;

    assign stage_req = '{vd: stageWrite_bits_vd, offset: stageWrite_bits_offset,
                         mask: stageWrite_bits_mask, data: stageWrite_bits_data,
                         last: stageWrite_bits_last,
                         instructionIndex: stageWrite_bits_instructionIndex};
    assign lsu_req   = '{vd: lsuWrite_bits_vd, offset: lsuWrite_bits_offset,
                         mask: lsuWrite_bits_mask, data: lsuWrite_bits_data,
                         last: lsuWrite_bits_last,
                         instructionIndex: lsuWrite_bits_instructionIndex};

    // prefer_lsu_q set means stage3 won the last accepted grant.
    assign grant_stage      = stageWrite_valid & (~lsuWrite_valid | ~prefer_lsu_q);
    assign grant_lsu        = lsuWrite_valid & (~stageWrite_valid | prefer_lsu_q);
    assign stageWrite_ready = grant_stage & fifo_ready;
    assign lsuWrite_ready   = grant_lsu & fifo_ready;
    assign stage_acc        = stageWrite_valid & stageWrite_ready;
    assign lsu_acc          = lsuWrite_valid & lsuWrite_ready;
    assign win_req          = grant_lsu ? lsu_req : stage_req;

    // Empty-mask writes are swallowed unless they carry the retirement marker.
    assign enq = (stage_acc | lsu_acc) & ((|win_req.mask) | win_req.last);

    lane_write_fifo #(
        .DEPTH (OUT_DEPTH),
        .T     (vrf_write_req_t)
    ) u_out_fifo (
        .clk        (clock),
        .rst_n      (reset),
        .in_tdata   (win_req),
        .in_tvalid  (enq),
        .in_tready  (fifo_ready),
        .out_tdata  (head_req),
        .out_tvalid (vrfWrite_valid),
        .out_tready (vrfWrite_ready)
    );

    assign pop                            = vrfWrite_valid & vrfWrite_ready;
    assign vrfWrite_bits_vd               = head_req.vd;
    assign vrfWrite_bits_offset           = head_req.offset;
    assign vrfWrite_bits_mask             = head_req.mask;
    assign vrfWrite_bits_data             = head_req.data;
    assign vrfWrite_bits_last             = head_req.last;
    assign vrfWrite_bits_instructionIndex = head_req.instructionIndex;
    assign writeLastReport                = report_q;

    always_comb begin
        report_d = '0;
        if (pop && head_req.last) report_d = INST_SLOTS'(1) << head_req.instructionIndex;
        for (int i = 0; i < INST_SLOTS; i++) begin
            count_d[i] = count_q[i];
            if (enq && win_req.instructionIndex == IDX_WIDTH'(i)) count_d[i] = count_d[i] + 1'b1;
            if (pop && head_req.instructionIndex == IDX_WIDTH'(i)) count_d[i] = count_d[i] - 1'b1;
            instructionWriting[i] = (count_q[i] != '0);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prefer_lsu_q <= 1'b0;
            report_q     <= '0;
            for (int i = 0; i < INST_SLOTS; i++) count_q[i] <= '0;
        end else begin
            if (stage_acc) prefer_lsu_q <= 1'b1;
            else if (lsu_acc) prefer_lsu_q <= 1'b0;
            report_q <= report_d;
            for (int i = 0; i < INST_SLOTS; i++) count_q[i] <= count_d[i];
        end
    end

    for (genvar g = 0; g < INST_SLOTS; g++) begin : g_cnt_chk
        a_cnt_bound: assert property (@(posedge clock) disable iff (!reset)
                                      count_q[g] <= CNT_W'(OUT_DEPTH));
    end

endmodule

// File: tb/tb_lane_vrf_write_arbiter.sv
// tb/tb_lane_vrf_write_arbiter.sv - directed vector bench for lane_vrf_write_arbiter
module tb_lane_vrf_write_arbiter;
    import lane_vrf_write_arbiter_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic           s_valid, l_valid, v_ready;
    vrf_write_req_t s_req, l_req, v_req;
    logic           s_ready, l_ready, v_valid;
    logic [4:0]     o_vd;
    logic [8:0]     o_off;
    logic [3:0]     o_mask;
    logic [31:0]    o_data;
    logic           o_last;
    logic [2:0]     o_idx;
    logic [7:0]     iw, wlr;

    assign v_req = vrf_write_req_t'({o_vd, o_off, o_mask, o_data, o_last, o_idx});

    lane_vrf_write_arbiter #(.OUT_DEPTH(2)) dut (
        .clock                            (clock),
        .reset                            (reset),
        .stageWrite_valid                 (s_valid),
        .stageWrite_ready                 (s_ready),
        .stageWrite_bits_vd               (s_req.vd),
        .stageWrite_bits_offset           (s_req.offset),
        .stageWrite_bits_mask             (s_req.mask),
        .stageWrite_bits_data             (s_req.data),
        .stageWrite_bits_last             (s_req.last),
        .stageWrite_bits_instructionIndex (s_req.instructionIndex),
        .lsuWrite_valid                   (l_valid),
        .lsuWrite_ready                   (l_ready),
        .lsuWrite_bits_vd                 (l_req.vd),
        .lsuWrite_bits_offset             (l_req.offset),
        .lsuWrite_bits_mask               (l_req.mask),
        .lsuWrite_bits_data               (l_req.data),
        .lsuWrite_bits_last               (l_req.last),
        .lsuWrite_bits_instructionIndex   (l_req.instructionIndex),
        .vrfWrite_valid                   (v_valid),
        .vrfWrite_ready                   (v_ready),
        .vrfWrite_bits_vd                 (o_vd),
        .vrfWrite_bits_offset             (o_off),
        .vrfWrite_bits_mask               (o_mask),
        .vrfWrite_bits_data               (o_data),
        .vrfWrite_bits_last               (o_last),
        .vrfWrite_bits_instructionIndex   (o_idx),
        .instructionWriting               (iw),
        .writeLastReport                  (wlr)
    );

    typedef struct {
        logic           sv;
        vrf_write_req_t sr;
        logic           lv;
        vrf_write_req_t lr;
        logic           vr;
        logic           es, el, ev;
        vrf_write_req_t evq;
        logic [7:0]     eiw, ewlr;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   passes = 0;

    function automatic vrf_write_req_t rq(input logic [4:0] vd, input logic [8:0] off,
                                          input logic [3:0] m, input logic [31:0] d,
                                          input logic l, input logic [2:0] ix);
        return '{vd: vd, offset: off, mask: m, data: d, last: l, instructionIndex: ix};
    endfunction

    function automatic vec_t mkv(input logic sv, input vrf_write_req_t sr,
                                 input logic lv, input vrf_write_req_t lr, input logic vr,
                                 input logic es, input logic el, input logic ev,
                                 input vrf_write_req_t evq, input logic [7:0] eiw,
                                 input logic [7:0] ewlr);
        vec_t v;
        v.sv = sv; v.sr = sr; v.lv = lv; v.lr = lr; v.vr = vr;
        v.es = es; v.el = el; v.ev = ev; v.evq = evq; v.eiw = eiw; v.ewlr = ewlr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    // Drive one cycle's inputs just after the rising edge, return at the falling edge.
    task automatic drive(input logic sv, input vrf_write_req_t sr, input logic lv,
                         input vrf_write_req_t lr, input logic vr);
        @(posedge clock);
        #1;
        s_valid = sv; s_req = sr; l_valid = lv; l_req = lr; v_ready = vr;
        @(negedge clock);
    endtask

    vrf_write_req_t z, a, d0, d1, g0, g1, g2, h0, h1, j0, k0;
    vrf_write_req_t s_k [4];
    vrf_write_req_t l_k [4];
    vrf_write_req_t f_k [4];

    initial begin
        z  = '0;
        a  = rq(5'd3, 9'h10, 4'hF, 32'hDEADBEEF, 1'b0, 3'd2);
        d0 = rq(5'd4, 9'h20, 4'h0, 32'h55, 1'b0, 3'd5);
        d1 = rq(5'd4, 9'h21, 4'h0, 32'h66, 1'b1, 3'd5);
        for (int k = 0; k < 4; k++) begin
            s_k[k] = rq(5'd1, 9'(k), 4'hF, 32'h1000 + k, 1'b0, 3'd0);
            l_k[k] = rq(5'd2, 9'(k), 4'hF, 32'h2000 + k, 1'b0, 3'd1);
            f_k[k] = rq(5'd6, 9'h30 + 9'(k), 4'hF, 32'hA0 + k, 1'b0, 3'd1);
        end

        // Alternating grants from the reset priority.
        tbl.push_back(mkv(1, s_k[0], 1, l_k[0], 1, 1, 0, 0, z,      8'h00, 8'h00));
        tbl.push_back(mkv(1, s_k[1], 1, l_k[1], 1, 0, 1, 1, s_k[0], 8'h01, 8'h00));
        tbl.push_back(mkv(1, s_k[2], 1, l_k[2], 1, 1, 0, 1, l_k[1], 8'h02, 8'h00));
        tbl.push_back(mkv(1, s_k[3], 1, l_k[3], 1, 0, 1, 1, s_k[2], 8'h01, 8'h00));
        tbl.push_back(mkv(0, z, 0, z, 1, 0, 0, 1, l_k[3], 8'h02, 8'h00));
        tbl.push_back(mkv(0, z, 0, z, 1, 0, 0, 0, z,      8'h00, 8'h00));
        // Single stage3 write, one cycle latency.
        tbl.push_back(mkv(1, a, 0, z, 1, 1, 0, 0, z, 8'h00, 8'h00));
        tbl.push_back(mkv(0, z, 0, z, 1, 0, 0, 1, a, 8'h04, 8'h00));
        tbl.push_back(mkv(0, z, 0, z, 1, 0, 0, 0, z, 8'h00, 8'h00));
        // Empty-mask drop, then empty-mask last marker.
        tbl.push_back(mkv(0, z, 1, d0, 1, 0, 1, 0, z,  8'h00, 8'h00));
        tbl.push_back(mkv(0, z, 0, z,  1, 0, 0, 0, z,  8'h00, 8'h00));
        tbl.push_back(mkv(0, z, 1, d1, 1, 0, 1, 0, z,  8'h00, 8'h00));
        tbl.push_back(mkv(0, z, 0, z,  1, 0, 0, 1, d1, 8'h20, 8'h00));
        tbl.push_back(mkv(0, z, 0, z,  1, 0, 0, 0, z,  8'h00, 8'h20));
        tbl.push_back(mkv(0, z, 0, z,  1, 0, 0, 0, z,  8'h00, 8'h00));
        // Fill with idx 1, full blocks ready even while popping, then push+pop same index.
        tbl.push_back(mkv(1, f_k[0], 0, z, 0, 1, 0, 0, z,      8'h00, 8'h00));
        tbl.push_back(mkv(1, f_k[1], 0, z, 0, 1, 0, 1, f_k[0], 8'h02, 8'h00));
        tbl.push_back(mkv(1, f_k[2], 0, z, 1, 0, 0, 1, f_k[0], 8'h02, 8'h00));
        tbl.push_back(mkv(1, f_k[2], 0, z, 1, 1, 0, 1, f_k[1], 8'h02, 8'h00));
        tbl.push_back(mkv(1, f_k[3], 0, z, 1, 1, 0, 1, f_k[2], 8'h02, 8'h00));
        tbl.push_back(mkv(0, z, 0, z, 1, 0, 0, 1, f_k[3], 8'h02, 8'h00));
        tbl.push_back(mkv(0, z, 0, z, 1, 0, 0, 0, z,      8'h00, 8'h00));

        s_valid = 0; l_valid = 0; v_ready = 0; s_req = '0; l_req = '0;
        #2;
        chk("reset_vvalid", 64'(v_valid), 64'h0);
        chk("reset_iw",     64'(iw),      64'h0);
        chk("reset_wlr",    64'(wlr),     64'h0);
        chk("reset_vdata",  64'(v_req),   64'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].sv, tbl[i].sr, tbl[i].lv, tbl[i].lr, tbl[i].vr);
            chk($sformatf("row%0d_sready", i), 64'(s_ready), 64'(tbl[i].es));
            chk($sformatf("row%0d_lready", i), 64'(l_ready), 64'(tbl[i].el));
            chk($sformatf("row%0d_vvalid", i), 64'(v_valid), 64'(tbl[i].ev));
            chk($sformatf("row%0d_iw", i),     64'(iw),      64'(tbl[i].eiw));
            chk($sformatf("row%0d_wlr", i),    64'(wlr),     64'(tbl[i].ewlr));
            if (tbl[i].ev) chk($sformatf("row%0d_vbits", i), 64'(v_req), 64'(tbl[i].evq));
        end

        // Back-pressure: two fill the FIFO, the third waits until a slot frees.
        for (int k = 0; k < 3; k++) begin
            vrf_write_req_t t;
            t = rq(5'd8, 9'h50 + 9'(k), 4'hF, 32'hC0 + k, 1'b0, 3'd6);
            if (k == 0) g0 = t; else if (k == 1) g1 = t; else g2 = t;
        end
        drive(1, g0, 0, z, 0);
        chk("bp_g0_ready", 64'(s_ready), 64'h1);
        chk("bp_g0_vvalid", 64'(v_valid), 64'h0);
        drive(1, g1, 0, z, 0);
        chk("bp_g1_ready", 64'(s_ready), 64'h1);
        chk("bp_g1_head", 64'(v_req), 64'(g0));
        drive(1, g2, 0, z, 0);
        chk("bp_g2_blocked", 64'(s_ready), 64'h0);
        chk("bp_iw", 64'(iw), 64'h40);
        drive(1, g2, 0, z, 1);
        chk("bp_g2_blocked_popping", 64'(s_ready), 64'h0);
        chk("bp_head_g0", 64'(v_req), 64'(g0));
        drive(1, g2, 0, z, 1);
        chk("bp_g2_ready", 64'(s_ready), 64'h1);
        chk("bp_head_g1", 64'(v_req), 64'(g1));
        drive(0, z, 0, z, 1);
        chk("bp_head_g2", 64'(v_req), 64'(g2));
        chk("bp_g2_valid", 64'(v_valid), 64'h1);
        drive(0, z, 0, z, 1);
        chk("bp_drained", 64'(v_valid), 64'h0);

        // Reset with two buffered entries and a last report in flight.
        h0 = rq(5'd7, 9'h40, 4'hF, 32'hB0, 1'b1, 3'd3);
        h1 = rq(5'd7, 9'h41, 4'hF, 32'hB1, 1'b1, 3'd4);
        drive(1, h0, 0, z, 0);
        drive(1, h1, 0, z, 0);
        drive(0, z, 0, z, 1);
        chk("rst_head_h0", 64'(v_req), 64'(h0));
        @(posedge clock);
        #1;
        v_ready = 0;
        chk("rst_pre_wlr",    64'(wlr),     64'h08);
        chk("rst_pre_iw",     64'(iw),      64'h10);
        chk("rst_pre_vvalid", 64'(v_valid), 64'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_vvalid", 64'(v_valid), 64'h0);
        chk("rst_async_iw",     64'(iw),      64'h0);
        chk("rst_async_wlr",    64'(wlr),     64'h0);
        chk("rst_async_vbits",  64'(v_req),   64'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        j0 = rq(5'd9, 9'h60, 4'h3, 32'hE0, 1'b0, 3'd7);
        k0 = rq(5'd10, 9'h61, 4'hC, 32'hE1, 1'b0, 3'd0);
        drive(1, j0, 1, k0, 1);
        chk("post_rst_stage_prio", 64'(s_ready), 64'h1);
        chk("post_rst_lsu_wait",   64'(l_ready), 64'h0);
        chk("post_rst_empty",      64'(v_valid), 64'h0);
        drive(0, z, 0, z, 1);
        chk("post_rst_head_j0", 64'(v_req), 64'(j0));
        chk("post_rst_iw",      64'(iw),    64'h80);
        drive(0, z, 0, z, 1);
        chk("post_rst_drained", 64'(v_valid), 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
